// File: rtl/run_sequencer.sv
// Purpose : host-side job sequencer for the 9-bit-ISA core: load data memory, pulse core start, wait for done, unload results.
// Latency : load/unload write or read one byte per handshake with combinational memory access; START lasts START_CYCLES cycles.
// Backpres: in_ready is high for the whole LOAD phase; out_valid/out_data hold steady in UNLOAD until out_ready.
//
// Ports:
//   clk, reset (async, active-low)       -- clocking and reset
//   go                                   -- start a job from IDLE/DONE/ERR
//   in_valid/in_ready/in_data            -- input byte stream written to memory during LOAD
//   out_valid/out_ready/out_data         -- result byte stream read from memory during UNLOAD
//   mem_sel/mem_addr/mem_wr_en/          -- data-memory port (mem_sel=1: sequencer owns it)
//   mem_wr_data/mem_rd_data
//   core_start/core_done                 -- core reset/start control and completion level
//   busy/err/run_cycles                  -- job status, sticky timeout flag, saturating RUN cycle count
module run_sequencer #(
    parameter int LOAD_BASE    = 0,
    parameter int LOAD_LEN     = 64,
    parameter int UNLOAD_BASE  = 64,
    parameter int UNLOAD_LEN   = 64,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        mem_sel,
    output logic [7:0]  mem_addr,
    output logic        mem_wr_en,
    output logic [7:0]  mem_wr_data,
    input  logic [7:0]  mem_rd_data,
    output logic        core_start,
    input  logic        core_done,
    output logic        busy,
    output logic        err,
    output logic [15:0] run_cycles
);

    localparam logic [7:0]  LOAD_BASE_B   = 8'(LOAD_BASE);
    localparam logic [7:0]  UNLOAD_BASE_B = 8'(UNLOAD_BASE);
    localparam logic [8:0]  LOAD_LAST     = 9'(LOAD_LEN - 1);
    localparam logic [8:0]  UNLOAD_LAST   = 9'(UNLOAD_LEN - 1);
    localparam int          SCNT_W        = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [SCNT_W-1:0] START_LAST = SCNT_W'(START_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_V     = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_UNLOAD,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [8:0]         idx_q, idx_d;
    logic [SCNT_W-1:0]  scnt_q, scnt_d;
    logic [15:0]        run_cycles_q, run_cycles_d;
    logic               err_q, err_d;
    logic [15:0]        run_inc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            scnt_q       <= '0;
            run_cycles_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            scnt_q       <= scnt_d;
            run_cycles_q <= run_cycles_d;
            err_q        <= err_d;
        end
    end

    // Saturating increment so a long run never wraps the reported count.
    assign run_inc = (run_cycles_q == 16'hFFFF) ? run_cycles_q : run_cycles_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        scnt_d       = scnt_q;
        run_cycles_d = run_cycles_q;
        err_d        = err_q;

        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_data     = 8'h00;
        mem_sel      = 1'b1;
        mem_addr     = 8'h00;
        mem_wr_en    = 1'b0;
        mem_wr_data  = 8'h00;
        core_start   = 1'b1;    // core stays parked in reset unless running
        busy         = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (go) begin
                    idx_d        = '0;
                    run_cycles_d = '0;
                    err_d        = 1'b0;
                    state_d      = S_LOAD;
                end
            end

            S_LOAD: begin
                busy        = 1'b1;
                in_ready    = 1'b1;
                mem_addr    = LOAD_BASE_B + idx_q[7:0];
                mem_wr_data = in_data;
                mem_wr_en   = in_valid;
                if (in_valid) begin
                    if (idx_q == LOAD_LAST) begin
                        idx_d   = '0;
                        scnt_d  = '0;
                        state_d = S_START;
                    end else begin
                        idx_d = idx_q + 9'd1;
                    end
                end
            end

            S_START: begin
                busy    = 1'b1;
                mem_sel = 1'b0;
                scnt_d  = scnt_q + 1'b1;
                if (scnt_q == START_LAST) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                busy         = 1'b1;
                mem_sel      = 1'b0;
                core_start   = 1'b0;
                run_cycles_d = run_inc;
                // Done takes priority over a timeout landing in the same cycle.
                if (core_done) begin
                    idx_d   = '0;
                    state_d = S_UNLOAD;
                end else if (run_inc >= TIMEOUT_V) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
            end

            S_UNLOAD: begin
                busy      = 1'b1;
                mem_addr  = UNLOAD_BASE_B + idx_q[7:0];
                out_valid = 1'b1;
                out_data  = mem_rd_data;
                if (out_ready) begin
                    idx_d = idx_q + 9'd1;
                    if (idx_q == UNLOAD_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign err        = err_q;
    assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: instance A (defaults, TIMEOUT=100) covers reset, gapped load,
// run, backpressured unload and timeout; instance B covers single-byte load/unload at 0xFF.
// Each instance has a combinational-read, clocked-write memory model in the bench.
module tb_run_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A signals
    logic        go, in_valid, in_ready, out_valid, out_ready, mem_sel, mem_wr_en;
    logic        core_start, core_done, busy, err;
    logic [7:0]  in_data, out_data, mem_addr, mem_wr_data, mem_rd_data;
    logic [15:0] run_cycles;

    // Instance B signals
    logic        go_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, mem_sel_b, mem_wr_en_b;
    logic        core_start_b, core_done_b, busy_b, err_b;
    logic [7:0]  in_data_b, out_data_b, mem_addr_b, mem_wr_data_b, mem_rd_data_b;
    logic [15:0] run_cycles_b;

    logic [7:0]  mem_a [256];
    logic [7:0]  mem_b [256];
    logic        preload;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_wr[$];     // {addr, data} of each expected memory write
    logic [7:0]  exp_out[$];    // expected unload bytes, instance A
    logic [7:0]  exp_out_b[$];  // expected unload bytes, instance B

    run_sequencer #(.TIMEOUT(100)) u_dut_a (
        .clk(clk), .reset(reset), .go(go),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .core_start(core_start), .core_done(core_done),
        .busy(busy), .err(err), .run_cycles(run_cycles)
    );

    run_sequencer #(.LOAD_LEN(1), .UNLOAD_BASE(255), .UNLOAD_LEN(1)) u_dut_b (
        .clk(clk), .reset(reset), .go(go_b),
        .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
        .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(out_ready_b),
        .mem_sel(mem_sel_b), .mem_addr(mem_addr_b), .mem_wr_en(mem_wr_en_b),
        .mem_wr_data(mem_wr_data_b), .mem_rd_data(mem_rd_data_b),
        .core_start(core_start_b), .core_done(core_done_b),
        .busy(busy_b), .err(err_b), .run_cycles(run_cycles_b)
    );

    assign mem_rd_data   = mem_a[mem_addr];
    assign mem_rd_data_b = mem_b[mem_addr_b];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem_a[64+i] <= 8'(8'hA0 + i);
            mem_b[255] <= 8'h5A;
        end else begin
            if (mem_sel && mem_wr_en)     mem_a[mem_addr]   <= mem_wr_data;
            if (mem_sel_b && mem_wr_en_b) mem_b[mem_addr_b] <= mem_wr_data_b;
        end
    end

    task automatic test_reset();
        #1;
        n_checks++;
        if ({core_start, mem_sel, in_ready, out_valid, mem_wr_en, busy, err} !== 7'b1100000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 1100000",
                     {core_start, mem_sel, in_ready, out_valid, mem_wr_en, busy, err});
        end
        n_checks++;
        if (run_cycles !== 16'd0) begin
            n_fail++; $display("FAIL reset_run_cycles: got %0d expected 0", run_cycles);
        end
        @(negedge clk); reset = 1'b1;
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; in_data = 8'(k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (mem_addr !== 8'd10) begin
            n_fail++; $display("FAIL reset_pre_idx: got addr %0d expected 10", mem_addr);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, core_start, err, busy, mem_sel} !== 5'b01001) begin
            n_fail++;
            $display("FAIL reset_mid_load: got %b expected 01001", {in_ready, core_start, err, busy, mem_sel});
        end
        @(negedge clk); reset = 1'b1; go = 1'b1;
        @(negedge clk); go = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, mem_addr} !== {1'b1, 8'd0}) begin
            n_fail++; $display("FAIL reset_restart: got rdy %b addr %0d expected rdy 1 addr 0", in_ready, mem_addr);
        end
        reset = 1'b0;
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_load_gaps();
        int sent = 0, writes = 0, cyc = 0, scyc = 0, sbad = 0, g = 0, membad = 0;
        logic [15:0] exp;
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        while (sent < 64 && cyc < 400) begin
            in_valid = (cyc % 2) == 1;
            in_data  = 8'(sent);
            if (in_valid) exp_wr.push_back({8'(sent), 8'(sent)});
            #1;
            n_checks++;
            if (mem_wr_en !== in_valid) begin
                n_fail++; $display("FAIL load_wr_en: got %b expected %b at byte %0d", mem_wr_en, in_valid, sent);
            end
            if (mem_wr_en === 1'b1) begin
                writes++;
                exp = (exp_wr.size() > 0) ? exp_wr.pop_front() : 16'hxxxx;
                n_checks++;
                if ({mem_addr, mem_wr_data} !== exp) begin
                    n_fail++; $display("FAIL load_write: got %h expected %h", {mem_addr, mem_wr_data}, exp);
                end
            end
            if (in_valid && in_ready) sent++;
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if (writes !== 64) begin
            n_fail++; $display("FAIL load_write_count: got %0d expected 64", writes);
        end
        for (int i = 0; i < 64; i++) if (mem_a[i] !== 8'(i)) membad++;
        n_checks++;
        if (membad !== 0) begin
            n_fail++; $display("FAIL load_mem_contents: got %0d bad bytes expected 0", membad);
        end
        #1;
        while (core_start && g < 20) begin
            if (mem_sel !== 1'b0) sbad++;
            scyc++;
            @(negedge clk); #1;
            g++;
        end
        n_checks++;
        if (scyc !== 2 || sbad !== 0) begin
            n_fail++; $display("FAIL start_cycles: got %0d (sel bad %0d) expected 2 (0)", scyc, sbad);
        end
    endtask

    task automatic test_run();
        int sel_bad = 0;
        if (mem_sel !== 1'b0) sel_bad++;
        for (int k = 2; k <= 38; k++) begin
            @(negedge clk);
            go        = (k == 5);
            core_done = (k == 38);
            #1;
            if (mem_sel !== 1'b0 || core_start !== 1'b0 || busy !== 1'b1) sel_bad++;
        end
        @(negedge clk); go = 1'b0; core_done = 1'b0;
        #1;
        n_checks++;
        if (sel_bad !== 0) begin
            n_fail++; $display("FAIL run_mem_sel: got %0d bad cycles expected 0", sel_bad);
        end
        n_checks++;
        if (run_cycles !== 16'd38) begin
            n_fail++; $display("FAIL run_cycles: got %0d expected 38", run_cycles);
        end
        n_checks++;
        if ({out_valid, mem_sel, core_start} !== 3'b111) begin
            n_fail++; $display("FAIL run_to_unload: got %b expected 111", {out_valid, mem_sel, core_start});
        end
    endtask

    task automatic test_unload_backpressure();
        int got = 0, stall = 0, stall_bad = 0, cyc = 0;
        logic [7:0] exp;
        while (got < 64 && cyc < 400) begin
            @(negedge clk);
            out_ready = !(got == 3 && stall < 5);
            if (!out_ready) stall++;
            #1;
            exp = (exp_out.size() > 0) ? exp_out[0] : 8'hxx;
            n_checks++;
            if ({out_valid, out_data, mem_addr} !== {1'b1, exp, 8'(64 + got)}) begin
                n_fail++;
                $display("FAIL unload_byte: got v%b d%h a%0d expected v1 d%h a%0d",
                         out_valid, out_data, mem_addr, exp, 64 + got);
            end
            if (!out_ready && out_data !== 8'hA3) stall_bad++;
            if (out_valid && out_ready) begin
                void'(exp_out.pop_front());
                got++;
            end
            cyc++;
        end
        @(negedge clk); out_ready = 1'b0;
        #1;
        n_checks++;
        if (got !== 64 || stall !== 5 || stall_bad !== 0) begin
            n_fail++; $display("FAIL unload_count: got %0d bytes %0d stalls %0d bad expected 64 5 0", got, stall, stall_bad);
        end
        n_checks++;
        if ({busy, out_valid, core_start, mem_sel, err} !== 5'b00110) begin
            n_fail++; $display("FAIL unload_done: got %b expected 00110", {busy, out_valid, core_start, mem_sel, err});
        end
    endtask

    task automatic test_timeout();
        int g = 0, rc = 0;
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        for (int k = 0; k < 64; k++) begin
            in_valid = 1'b1; in_data = 8'(k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        while (core_start && g < 20) begin @(negedge clk); #1; g++; end
        while (!core_start && rc < 300) begin rc++; @(negedge clk); #1; end
        n_checks++;
        if (rc !== 100) begin
            n_fail++; $display("FAIL timeout_run_len: got %0d expected 100", rc);
        end
        n_checks++;
        if ({err, busy, run_cycles} !== {1'b1, 1'b0, 16'd100}) begin
            n_fail++; $display("FAIL timeout_flags: got err %b busy %b rc %0d expected 1 0 100", err, busy, run_cycles);
        end
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        #1;
        n_checks++;
        if ({err, in_ready, busy, run_cycles} !== {1'b0, 1'b1, 1'b1, 16'd0}) begin
            n_fail++; $display("FAIL timeout_go_clears: got err %b rdy %b busy %b rc %0d expected 0 1 1 0",
                               err, in_ready, busy, run_cycles);
        end
    endtask

    task automatic test_edge_single();
        int g = 0;
        logic [7:0] exp;
        @(negedge clk); go_b = 1'b1;
        @(negedge clk); go_b = 1'b0; in_valid_b = 1'b1; in_data_b = 8'hC3;
        #1;
        n_checks++;
        if ({mem_wr_en_b, mem_addr_b, mem_wr_data_b} !== {1'b1, 8'h00, 8'hC3}) begin
            n_fail++; $display("FAIL edge_write: got %b %h %h expected 1 00 c3", mem_wr_en_b, mem_addr_b, mem_wr_data_b);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({in_ready_b, mem_wr_en_b, core_start_b} !== 3'b001) begin
            n_fail++; $display("FAIL edge_single_write: got %b expected 001", {in_ready_b, mem_wr_en_b, core_start_b});
        end
        in_valid_b = 1'b0;
        while (core_start_b && g < 20) begin @(negedge clk); #1; g++; end
        core_done_b = 1'b1;
        @(negedge clk); core_done_b = 1'b0; out_ready_b = 1'b1;
        #1;
        exp = (exp_out_b.size() > 0) ? exp_out_b.pop_front() : 8'hxx;
        n_checks++;
        if ({run_cycles_b, out_valid_b, mem_addr_b, out_data_b} !== {16'd1, 1'b1, 8'hFF, exp}) begin
            n_fail++; $display("FAIL edge_unload: got rc %0d v %b a %h d %h expected 1 1 ff %h",
                               run_cycles_b, out_valid_b, mem_addr_b, out_data_b, exp);
        end
        @(negedge clk); out_ready_b = 1'b0;
        #1;
        n_checks++;
        if ({busy_b, out_valid_b, mem_b[0]} !== {1'b0, 1'b0, 8'hC3}) begin
            n_fail++; $display("FAIL edge_done: got busy %b v %b mem0 %h expected 0 0 c3", busy_b, out_valid_b, mem_b[0]);
        end
    endtask

    initial begin
        reset = 1'b0; preload = 1'b1;
        go = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; core_done = 1'b0;
        go_b = 1'b0; in_valid_b = 1'b0; in_data_b = 8'h00; out_ready_b = 1'b0; core_done_b = 1'b0;
        for (int i = 0; i < 64; i++) exp_out.push_back(8'(8'hA0 + i));
        exp_out_b.push_back(8'h5A);
        repeat (2) @(negedge clk);
        preload = 1'b0;
        test_reset();
        test_load_gaps();
        test_run();
        test_unload_backpressure();
        test_timeout();
        test_edge_single();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
